// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, talks to instruction memory over a req/ack
// handshake, buffers a word across stalls and discards stale data after redirects.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallF,
  input  logic        BranchTakenD,
  input  logic [31:0] BranchTargetD,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PCPlus4F,
  output logic [31:0] InstructionF,
  output logic        IFflush
);

  typedef enum logic [1:0] {StReq, StHold, StKill} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] hold_instr_q, hold_instr_d;
  logic [31:0] hold_pc4_q, hold_pc4_d;
  logic [31:0] kill_addr_q, kill_addr_d;
  logic [31:0] pc_plus4;

  assign pc_plus4 = pc_q + 32'd4;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StReq;
      pc_q         <= RESET_PC;
      hold_instr_q <= 32'h0;
      hold_pc4_q   <= 32'h0;
      kill_addr_q  <= 32'h0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      hold_instr_q <= hold_instr_d;
      hold_pc4_q   <= hold_pc4_d;
      kill_addr_q  <= kill_addr_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    hold_instr_d = hold_instr_q;
    hold_pc4_d   = hold_pc4_q;
    kill_addr_d  = kill_addr_q;
    if (BranchTakenD) begin
      pc_d         = BranchTargetD;
      hold_instr_d = 32'h0;
      hold_pc4_d   = 32'h0;
      state_d      = StReq;
      // An un-acked request must still complete; keep its address stable meanwhile.
      if (!imem_ack && state_q == StReq) begin
        state_d     = StKill;
        kill_addr_d = pc_q;
      end else if (!imem_ack && state_q == StKill) begin
        state_d = StKill;
      end
    end else begin
      unique case (state_q)
        StReq: begin
          if (imem_ack && stallF) begin
            hold_instr_d = imem_rdata;
            hold_pc4_d   = pc_plus4;
            state_d      = StHold;
          end else if (imem_ack) begin
            pc_d = pc_plus4;
          end
        end
        StHold: begin
          if (!stallF) begin
            pc_d    = pc_plus4;
            state_d = StReq;
          end
        end
        StKill: begin
          if (imem_ack) state_d = StReq;
        end
        default: state_d = StReq;
      endcase
    end
  end

  always_comb begin
    imem_req     = 1'b0;
    imem_addr    = pc_q;
    InstructionF = 32'h0;
    PCPlus4F     = 32'h0;
    IFflush      = BranchTakenD & ~rst;
    if (rst) begin
      imem_addr = RESET_PC;
    end else begin
      unique case (state_q)
        StReq: begin
          imem_req = 1'b1;
          if (imem_ack && !stallF && !BranchTakenD) begin
            InstructionF = imem_rdata;
            PCPlus4F     = pc_plus4;
          end
        end
        StHold: begin
          if (!BranchTakenD) begin
            InstructionF = hold_instr_q;
            PCPlus4F     = hold_pc4_q;
          end
        end
        StKill: begin
          imem_req  = 1'b1;
          imem_addr = kill_addr_q;
        end
        default: imem_req = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed walk through the fetch scenarios, then random traffic,
// all checked against a flag-based behavioural model of the fetch stage.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stallF = 1'b0;
  logic        BranchTakenD = 1'b0;
  logic [31:0] BranchTargetD = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] PCPlus4F;
  logic [31:0] InstructionF;
  logic        IFflush;

  fetch_unit dut (
    .clk          (clk),
    .rst          (rst),
    .stallF       (stallF),
    .BranchTakenD (BranchTakenD),
    .BranchTargetD(BranchTargetD),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .PCPlus4F     (PCPlus4F),
    .InstructionF (InstructionF),
    .IFflush      (IFflush)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Model: the address the pipeline wants next, an optional parked word, and an
  // optional stale request that must drain before the target can be fetched.
  logic [31:0] m_pc = 32'h0;
  bit          m_parked = 0;
  logic [31:0] m_park_instr = 32'h0, m_park_pc4 = 32'h0;
  bit          m_stale = 0;
  logic [31:0] m_stale_addr = 32'h0;

  // Last sampled DUT outputs, for directed constant checks.
  logic        o_req;
  logic [31:0] o_addr, o_instr, o_pc4;
  logic        o_flush;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit model_req();
    return !m_parked;
  endfunction

  task automatic step(input bit r, input bit st, input bit b, input logic [31:0] t,
                      input bit a, input logic [31:0] d);
    logic        e_req, e_flush;
    logic [31:0] e_addr, e_instr, e_pc4;
    @(negedge clk);
    rst = r; stallF = st; BranchTakenD = b; BranchTargetD = t; imem_ack = a; imem_rdata = d;
    #1;
    e_req = 0; e_addr = 32'h0; e_instr = 32'h0; e_pc4 = 32'h0; e_flush = b && !r;
    if (!r) begin
      if (m_stale) begin
        e_req = 1; e_addr = m_stale_addr;
      end else if (m_parked) begin
        if (!b) begin e_instr = m_park_instr; e_pc4 = m_park_pc4; end
      end else begin
        e_req = 1; e_addr = m_pc;
        if (a && !st && !b) begin e_instr = d; e_pc4 = m_pc + 32'd4; end
      end
    end
    o_req = imem_req; o_addr = imem_addr; o_instr = InstructionF; o_pc4 = PCPlus4F;
    o_flush = IFflush;
    chk("imem_req", {31'h0, o_req}, {31'h0, e_req});
    if (e_req || r) chk("imem_addr", o_addr, e_addr);
    chk("InstructionF", o_instr, e_instr);
    chk("PCPlus4F", o_pc4, e_pc4);
    chk("IFflush", {31'h0, o_flush}, {31'h0, e_flush});
    // Advance the model with the values the DUT sees at the coming edge.
    if (r) begin
      m_pc = 32'h0; m_parked = 0; m_stale = 0; m_park_instr = 0; m_park_pc4 = 0;
    end else if (b) begin
      if (!m_parked && !a) begin
        if (!m_stale) m_stale_addr = m_pc;
        m_stale = 1;
      end else begin
        m_stale = 0;
      end
      m_parked = 0;
      m_pc = t;
    end else if (m_stale) begin
      if (a) m_stale = 0;
    end else if (m_parked) begin
      if (!st) begin m_parked = 0; m_pc = m_pc + 32'd4; end
    end else if (a) begin
      if (st) begin
        m_parked = 1; m_park_instr = d; m_park_pc4 = m_pc + 32'd4;
      end else begin
        m_pc = m_pc + 32'd4;
      end
    end
    @(posedge clk);
  endtask

  initial begin
    // Reset and zero-wait fetch
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1, 32'h1234_5678);
    chk("rst_instr", o_instr, 32'h0);
    chk("rst_addr", o_addr, 32'h0);
    step(0, 0, 0, 0, 1, 32'h2008_0005);
    chk("zw0_addr", o_addr, 32'h0);
    chk("zw0_instr", o_instr, 32'h2008_0005);
    chk("zw0_pc4", o_pc4, 32'h4);
    step(0, 0, 0, 0, 1, 32'h2009_0007);
    chk("zw1_addr", o_addr, 32'h4);
    chk("zw1_pc4", o_pc4, 32'h8);
    // Two wait states at 0x8
    step(0, 0, 0, 0, 0, 32'hDEAD_0000);
    step(0, 0, 0, 0, 0, 32'hDEAD_0001);
    chk("wait_addr", o_addr, 32'h8);
    chk("wait_pc4", o_pc4, 32'h0);
    step(0, 0, 0, 0, 1, 32'h0000_0013);
    chk("wait_done_pc4", o_pc4, 32'hC);
    // Stall across the ack at 0xC
    step(0, 1, 0, 0, 1, 32'h012A_4020);
    chk("stall_bubble", o_instr, 32'h0);
    step(0, 1, 0, 0, 0, 0);
    chk("hold_instr", o_instr, 32'h012A_4020);
    chk("hold_pc4", o_pc4, 32'h10);
    chk("hold_req", {31'h0, o_req}, 32'h0);
    step(0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("after_stall_addr", o_addr, 32'h10);
    // Redirect while the request at 0x10 is outstanding
    step(0, 0, 1, 32'h100, 0, 0);
    chk("kill_flush", {31'h0, o_flush}, 32'h1);
    step(0, 0, 0, 0, 0, 0);
    chk("kill_addr", o_addr, 32'h10);
    step(0, 0, 0, 0, 1, 32'hBAD0_BAD0);
    chk("kill_discard", o_instr, 32'h0);
    step(0, 0, 0, 0, 1, 32'h0000_0033);
    chk("target_addr", o_addr, 32'h100);
    // Redirect during HOLD with stall asserted
    step(0, 1, 0, 0, 1, 32'h0000_0044);
    step(0, 1, 1, 32'h200, 0, 0);
    chk("hold_redir_instr", o_instr, 32'h0);
    step(0, 0, 0, 0, 0, 0);
    chk("hold_redir_addr", o_addr, 32'h200);
    // Reset while killing a stale request
    step(0, 0, 1, 32'h300, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    chk("rst_kill_addr", o_addr, 32'h0);
    chk("rst_kill_req", {31'h0, o_req}, 32'h0);
    step(0, 0, 0, 0, 0, 0);
    chk("post_rst_addr", o_addr, 32'h0);
    // PC wrap
    step(0, 0, 1, 32'hFFFF_FFFC, 1, 32'h0000_0055);
    step(0, 0, 0, 0, 1, 32'h0000_0066);
    chk("wrap_pc4", o_pc4, 32'h0);
    step(0, 0, 0, 0, 0, 0);
    chk("wrap_addr", o_addr, 32'h0);
    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      bit r, st, b, a;
      r  = ($urandom_range(0, 63) == 0);
      st = ($urandom_range(0, 2) == 0);
      b  = ($urandom_range(0, 7) == 0);
      a  = !r && model_req() && ($urandom_range(0, 1) == 1);
      step(r, st, b, $urandom(), a, $urandom());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
